// File: rtl/fpu_result_pkg.sv
// Shared definitions for the FPU result stage: exception codes, flag bit
// positions and the exponent-width helper used to size float fields.
package fpu_result_pkg;

  // Special-case code driven by the arithmetic core alongside each result
  typedef enum logic [2:0] {
    EXC_NONE    = 3'd0,
    EXC_INVALID = 3'd1,
    EXC_OVF     = 3'd2,
    EXC_UNF     = 3'd3,
    EXC_DZ      = 3'd4,
    EXC_COPY_A  = 3'd5,
    EXC_COPY_B  = 3'd6,
    EXC_RSVD    = 3'd7
  } exc_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
  localparam int FLAG_W = 5;

  // Exponent field width for the supported IEEE-754 formats
  function automatic int exp_w(input int width);
    case (width)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so that full
// and empty can be told apart when the index bits are equal.
module fpu_result_fifo #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage and pointer advance; a reset discards everything in flight
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fpu_result_stage.sv
// FPU result stage: picks the final IEEE-754 value (normal or special case),
// queues it with its flags for writeback and accumulates sticky flags.
module fpu_result_stage
  import fpu_result_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        R_normal,
  input  logic [2:0]              exception_flag,
  input  logic                    sign_a,
  input  logic                    sign_b,
  input  logic [WIDTH-2:0]        copied_operand,
  input  logic                    inexact,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        R,
  output logic [FLAG_W-1:0]       out_flags,
  output logic [FLAG_W-1:0]       fflags,
  input  logic                    fflags_clr,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int EXP_W   = exp_w(WIDTH);
  localparam int MAN_W   = WIDTH - 1 - EXP_W;
  localparam int ENTRY_W = WIDTH + FLAG_W;

  // Magnitude of infinity and the canonical quiet NaN for this format
  localparam logic [WIDTH-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic                 sx;
  logic [WIDTH-1:0]     r_sel;
  logic [FLAG_W-1:0]    flags_sel;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   head_data;
  logic [ENTRY_W-1:0]   held;
  logic [ENTRY_W-1:0]   shown;

  assign sx = sign_a ^ sign_b;

  // Choose the result value and its per-operation flags from the exception code
  always_comb begin
    r_sel     = '0;
    flags_sel = '0;
    case (exc_e'(exception_flag))
      EXC_NONE: begin
        r_sel             = R_normal;
        flags_sel[FLG_NX] = inexact;
      end
      EXC_INVALID, EXC_RSVD: begin
        r_sel             = QNAN;
        flags_sel[FLG_NV] = 1'b1;
      end
      EXC_OVF: begin
        r_sel             = {sx, INF_MAG};
        flags_sel[FLG_OF] = 1'b1;
        flags_sel[FLG_NX] = 1'b1;
      end
      EXC_UNF: begin
        r_sel             = {sx, {(WIDTH-1){1'b0}}};
        flags_sel[FLG_UF] = 1'b1;
        flags_sel[FLG_NX] = 1'b1;
      end
      EXC_DZ: begin
        r_sel             = {sx, INF_MAG};
        flags_sel[FLG_DZ] = 1'b1;
      end
      EXC_COPY_A: begin
        r_sel = {sign_a, copied_operand};
      end
      EXC_COPY_B: begin
        r_sel = {sign_b, copied_operand};
      end
    endcase
  end

  // in_ready depends only on stored state, so a full queue refuses a push
  // even in a cycle where writeback is popping
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fpu_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push),
    .pop    (pop),
    .wdata  ({r_sel, flags_sel}),
    .rdata  (head_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Remember the most recently consumed entry so outputs hold steady when empty
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      held <= '0;
    end else if (pop) begin
      held <= head_data;
    end
  end

  assign shown     = fifo_empty ? held : head_data;
  assign R         = shown[ENTRY_W-1:FLAG_W];
  assign out_flags = shown[FLAG_W-1:0];

  // Sticky flags accumulate on accept; a clear in the same cycle keeps only the new flags
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fflags <= '0;
    end else if (push) begin
      fflags <= (fflags_clr ? '0 : fflags) | flags_sel;
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_result_stage.sv
// Self-checking bench for fpu_result_stage: directed scenarios followed by
// random traffic, checked against a queue-based behavioural model.
module tb_fpu_result_stage;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  f;
  } ent_t;

  logic        clk;
  logic        arst_n;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] R_normal;
  logic [2:0]  exception_flag;
  logic        sign_a;
  logic        sign_b;
  logic [30:0] copied_operand;
  logic        inexact;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic [1:0]  fifo_level;

  logic        in_valid64;
  logic        in_ready64;
  logic [63:0] R_normal64;
  logic [2:0]  exception_flag64;
  logic        sign_a64;
  logic        sign_b64;
  logic [62:0] copied_operand64;
  logic        inexact64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] R64;
  logic [4:0]  out_flags64;
  logic [4:0]  fflags64;
  logic        fflags_clr64;
  logic [1:0]  fifo_level64;

  int   total;
  int   bad;
  ent_t q[$];
  ent_t held_e;
  logic [4:0] m_ff;

  fpu_result_stage #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .R_normal       (R_normal),
    .exception_flag (exception_flag),
    .sign_a         (sign_a),
    .sign_b         (sign_b),
    .copied_operand (copied_operand),
    .inexact        (inexact),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .R              (R),
    .out_flags      (out_flags),
    .fflags         (fflags),
    .fflags_clr     (fflags_clr),
    .fifo_level     (fifo_level)
  );

  fpu_result_stage #(.WIDTH(64), .DEPTH(2)) dut64 (
    .clk            (clk),
    .arst_n         (arst_n),
    .in_valid       (in_valid64),
    .in_ready       (in_ready64),
    .R_normal       (R_normal64),
    .exception_flag (exception_flag64),
    .sign_a         (sign_a64),
    .sign_b         (sign_b64),
    .copied_operand (copied_operand64),
    .inexact        (inexact64),
    .out_valid      (out_valid64),
    .out_ready      (out_ready64),
    .R              (R64),
    .out_flags      (out_flags64),
    .fflags         (fflags64),
    .fflags_clr     (fflags_clr64),
    .fifo_level     (fifo_level64)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference selection computed from the IEEE field layout of a w-bit float
  function automatic void model_sel(input int w, input logic [2:0] code,
                                    input logic sa, input logic sb,
                                    input logic [63:0] copied, input logic [63:0] rn,
                                    input logic inx,
                                    output logic [63:0] r, output logic [4:0] f);
    int ew;
    int mw;
    logic [63:0] sign_pos;
    logic [63:0] inf;
    logic [63:0] qnan;
    logic sx;
    ew       = (w == 16) ? 5 : (w == 64) ? 11 : 8;
    mw       = w - 1 - ew;
    sign_pos = 64'd1 << (w - 1);
    inf      = ((64'd1 << ew) - 64'd1) << mw;
    qnan     = inf | (64'd1 << (mw - 1));
    sx       = sa ^ sb;
    case (code)
      3'd0:    begin r = rn;                          f = {4'b0000, inx}; end
      3'd2:    begin r = (sx ? sign_pos : 64'd0) | inf; f = 5'b00101; end
      3'd3:    begin r = (sx ? sign_pos : 64'd0);       f = 5'b00011; end
      3'd4:    begin r = (sx ? sign_pos : 64'd0) | inf; f = 5'b01000; end
      3'd5:    begin r = (sa ? sign_pos : 64'd0) | copied; f = 5'b00000; end
      3'd6:    begin r = (sb ? sign_pos : 64'd0) | copied; f = 5'b00000; end
      default: begin r = qnan;                        f = 5'b10000; end
    endcase
  endfunction

  // One comparison: counts it and reports any disagreement
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operation on the 32-bit stage's input side
  task automatic apply_stimulus(input logic valid, input logic [2:0] code,
                                input logic sa, input logic sb,
                                input logic [30:0] copied, input logic [31:0] rn,
                                input logic inx, input logic rdy, input logic clr);
    in_valid       = valid;
    exception_flag = code;
    sign_a         = sa;
    sign_b         = sb;
    copied_operand = copied;
    R_normal       = rn;
    inexact        = inx;
    out_ready      = rdy;
    fflags_clr     = clr;
  endtask

  // Compare every visible output of the 32-bit stage with the model
  task automatic check_all(input string tag);
    ent_t shown;
    shown = (q.size() > 0) ? q[0] : held_e;
    check_output({tag, ":out_valid"}, out_valid, (q.size() > 0));
    check_output({tag, ":level"}, fifo_level, q.size());
    check_output({tag, ":in_ready"}, in_ready, (q.size() < DEPTH));
    check_output({tag, ":fflags"}, fflags, m_ff);
    check_output({tag, ":R"}, R, shown.r);
    check_output({tag, ":out_flags"}, out_flags, shown.f);
  endtask

  // Advance one clock, update the model with the handshakes seen at the edge
  task automatic cycle(input string tag);
    logic [63:0] er;
    logic [4:0]  ef;
    bit          do_push;
    bit          do_pop;
    model_sel(32, exception_flag, sign_a, sign_b, {33'd0, copied_operand},
              {32'd0, R_normal}, inexact, er, ef);
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) held_e = q.pop_front();
    if (do_push) begin
      q.push_back({er[31:0], ef});
      m_ff = (fflags_clr ? 5'd0 : m_ff) | ef;
    end else if (fflags_clr) begin
      m_ff = 5'd0;
    end
    check_all(tag);
  endtask

  // Linear directed sequence followed by random traffic
  initial begin
    total  = 0;
    bad    = 0;
    held_e = '0;
    m_ff   = '0;
    arst_n = 1'b0;
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    in_valid64       = 1'b0;
    R_normal64       = '0;
    exception_flag64 = 3'd0;
    sign_a64         = 1'b0;
    sign_b64         = 1'b0;
    copied_operand64 = '0;
    inexact64        = 1'b0;
    out_ready64      = 1'b0;
    fflags_clr64     = 1'b0;

    #12;
    check_all("reset");
    check_output("reset:R_hex", R, 32'h0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operations with writeback always ready: head is the latest push
    apply_stimulus(1'b1, 3'd1, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    in_valid64       = 1'b1;
    exception_flag64 = 3'd1;
    cycle("invalid");
    check_output("invalid:R_hex", R, 32'h7FC00000);
    check_output("invalid:flags_hex", out_flags, 5'b10000);
    check_output("invalid:fflags_hex", fflags, 5'b10000);
    check_output("w64:R_hex", R64, 64'h7FF8000000000000);
    check_output("w64:flags_hex", out_flags64, 5'b10000);
    check_output("w64:valid", out_valid64, 1'b1);
    in_valid64 = 1'b0;

    apply_stimulus(1'b1, 3'd2, 1'b1, 1'b0, 31'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    cycle("ovf");
    check_output("ovf:R_hex", R, 32'hFF800000);
    check_output("ovf:flags_hex", out_flags, 5'b00101);

    apply_stimulus(1'b1, 3'd4, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("dz");
    check_output("dz:R_hex", R, 32'h7F800000);
    check_output("dz:fflags_hex", fflags, 5'b01101);

    apply_stimulus(1'b1, 3'd5, 1'b1, 1'b0, 31'h3FC00000, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("copya");
    check_output("copya:R_hex", R, 32'hBFC00000);
    check_output("copya:flags_hex", out_flags, 5'b00000);

    apply_stimulus(1'b1, 3'd0, 1'b0, 1'b0, 31'd0, 32'h40490FDB, 1'b1, 1'b1, 1'b0);
    cycle("normal");
    check_output("normal:R_hex", R, 32'h40490FDB);
    check_output("normal:flags_hex", out_flags, 5'b00001);

    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("drain");
    check_output("drain:hold_R", R, 32'h40490FDB);

    // Backpressure: three valids, only two fit
    apply_stimulus(1'b1, 3'd6, 1'b0, 1'b1, 31'h11, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle("bp1");
    apply_stimulus(1'b1, 3'd6, 1'b0, 1'b0, 31'h22, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle("bp2");
    check_output("bp2:in_ready", in_ready, 1'b0);
    check_output("bp2:level", fifo_level, 2'd2);
    apply_stimulus(1'b1, 3'd6, 1'b1, 1'b1, 31'h33, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle("bp3");
    check_output("bp3:level", fifo_level, 2'd2);
    check_output("bp3:head_R", R, 32'h80000011);
    apply_stimulus(1'b1, 3'd6, 1'b1, 1'b1, 31'h33, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("bp4");
    check_output("bp4:head_R", R, 32'h00000022);
    check_output("bp4:level", fifo_level, 2'd1);
    cycle("bp5");
    check_output("bp5:head_R", R, 32'h80000033);
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("bp6");

    // Sticky clear together with an accept, then clear alone
    apply_stimulus(1'b1, 3'd3, 1'b0, 1'b1, 31'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    cycle("clrpush");
    check_output("clrpush:fflags_hex", fflags, 5'b00011);
    check_output("clrpush:R_hex", R, 32'h80000000);
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    cycle("clronly");
    check_output("clronly:fflags_hex", fflags, 5'd0);

    // Asynchronous reset with two entries queued
    apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle("pre_rst1");
    cycle("pre_rst2");
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 31'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    q.delete();
    held_e = '0;
    m_ff   = '0;
    check_all("async_rst");
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst:in_ready", in_ready, 1'b1);
    check_all("post_rst");

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom % 4) != 0, 3'($urandom), 1'($urandom), 1'($urandom),
                     31'($urandom), 32'($urandom), 1'($urandom),
                     ($urandom % 3) != 0, ($urandom % 16) == 0);
      cycle("rnd");
    end

    $display("[TB] directed and random phases complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
